alarm_sequencer: RTL and testbench
==================================

Name: alarm_sequencer

Overview:
- Control FSM that sits beside the 2-bit hours/minutes/seconds timekeeping counter.
- Sequences user set-up of the current time and the alarm time from single-cycle button pulses.
- Holds the armed alarm time and detects the match against the running time.
- Drives the buzzer through a ring / snooze / timeout sequence, and issues a one-cycle preset load strobe back to the timekeeper.

Parameters:
- W, 2, width of each hours/minutes/seconds field; all field arithmetic wraps modulo 2^W.
- RING_TICKS, 8, number of tick pulses the buzzer rings before auto-stop.
- SNOOZE_TICKS, 4, number of tick pulses spent in snooze before re-ringing.
- MAX_SNOOZE, 3, snoozes allowed per alarm event; used only with SNOOZE_LIMIT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle pulse per timekeeper second.
- cur_hours / cur_minutes / cur_seconds  in  W each  running time from the timekeeper.
- btn_mode, btn_inc, btn_arm, btn_snooze, btn_stop  in  1 each  single-cycle pulses, synchronised and debounced upstream.
- load  out  1  one-cycle strobe: timekeeper loads the preset fields.
- preset_hours / preset_minutes  out  W each  time to load; seconds load as 0.
- alarm_hours / alarm_minutes  out  W each  stored alarm time.
- armed  out  1  alarm enabled.
- buzzer  out  1  alarm sounding.
- mode  out  3  current state encoding.

Behaviour:
- Reset: state RUN (mode=0), all outputs and internal regs 0 (edit regs, alarm time, armed, load, buzzer, counters).
- State encodings: RUN=0, SET_TH=1, SET_TM=2, SET_AH=3, SET_AM=4, RINGING=5, SNOOZE=6.
- Mode cycle: in RUN/SET states, btn_mode advances RUN->SET_TH->SET_TM->SET_AH->SET_AM->RUN.
  - Entering SET_TH copies cur_hours/cur_minutes into the edit regs.
  - Entering SET_AH copies the alarm regs into the edit regs.
- btn_inc in SET_TH/SET_AH increments edit_h; in SET_TM/SET_AM increments edit_m. Increments wrap 2^W-1 -> 0.
- btn_inc in RUN, RINGING or SNOOZE is ignored.
- If btn_mode and btn_inc arrive in the same cycle, mode wins and inc is dropped.
- SET_TM -> SET_AH transition:
  - load=1 for exactly that one cycle (registered, asserted the cycle after the btn_mode press).
  - preset_* equal the edit regs and stay stable while load=1.
- SET_AM -> RUN transition: commit edit regs to alarm_hours/alarm_minutes and set armed=1.
- btn_arm in RUN toggles armed; btn_arm is ignored in all other states.
- Match is defined as cur_hours==alarm_hours and cur_minutes==alarm_minutes and cur_seconds==0.
  - Fire on the rising edge of match (registered match_q) when armed=1 and state=RUN.
  - Next edge: state=RINGING, buzzer=1, ring counter=0. One-cycle latency from the first match cycle.
  - A match in any other state, or a sustained match, does not fire.
- RINGING:
  - Priority is btn_stop > btn_snooze > timeout.
  - btn_stop -> RUN.
  - btn_snooze -> SNOOZE with snooze counter = SNOOZE_TICKS.
  - Ring counter counts tick pulses; on reaching RING_TICKS -> RUN.
  - buzzer=1 only while in RINGING.
- SNOOZE:
  - buzzer=0.
  - Each tick decrements the snooze counter; when it reaches 0 -> RINGING with ring counter cleared.
  - btn_stop -> RUN; btn_snooze is ignored.
- btn_mode is ignored in RINGING/SNOOZE.
- Returning to RUN from RINGING/SNOOZE leaves armed=1 and does not re-fire until match falls and rises again.
- Reset asserted mid-sequence (any state, including during load) aborts immediately: no load is issued and the alarm regs are cleared.

Optional Feature:
- Macro SNOOZE_LIMIT_EN.
- When defined:
  - A snooze count register (cleared on fire and on reset) increments per accepted snooze.
  - Once MAX_SNOOZE snoozes have been taken, btn_snooze in RINGING behaves as btn_stop.
- When undefined: unlimited snoozes; no counter logic is present.

Test Plan:
- Reset mid-RINGING -> same cycle: buzzer=0, mode=0, armed=0, alarm_hours=alarm_minutes=0.
- Time set: from RUN with cur=1:2:x, press mode, inc x2, mode, inc x3, mode -> edit regs held 3:1 (2+3 wrap 2^W); load=1 for one cycle with preset_hours=3, preset_minutes=1; mode=3.
- Alarm set and fire: set alarm 2:1 via SET_AH/SET_AM (armed=1), then drive cur 2:1:0 -> next cycle buzzer=1, mode=5; holding cur 2:1:0 for 5 cycles does not re-fire after stop.
- Ring timeout: RING_TICKS=8, no buttons, 8 tick pulses -> buzzer drops after 8th tick, mode=0; btn_snooze and btn_stop in the same cycle -> RUN (stop wins).
- Snooze: btn_snooze in RINGING -> mode=6, buzzer=0; 4 ticks -> mode=5, buzzer=1; btn_inc/btn_mode during snooze have no effect.
- With SNOOZE_LIMIT_EN, MAX_SNOOZE=3: fourth snooze press -> mode=0, buzzer=0; without the macro, fourth press -> mode=6.

Source files
------------

// File: rtl/alarm_sequencer.sv
// Alarm-clock control FSM: time/alarm set-up, alarm match, ring/snooze/timeout.
// Optional build macro SNOOZE_LIMIT_EN caps snoozes per alarm event at MAX_SNOOZE.
module alarm_sequencer #(
    parameter int W            = 2,
    parameter int RING_TICKS   = 8,
    parameter int SNOOZE_TICKS = 4,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic [W-1:0] cur_hours,
    input  logic [W-1:0] cur_minutes,
    input  logic [W-1:0] cur_seconds,
    input  logic         btn_mode,
    input  logic         btn_inc,
    input  logic         btn_arm,
    input  logic         btn_snooze,
    input  logic         btn_stop,
    output logic         load,
    output logic [W-1:0] preset_hours,
    output logic [W-1:0] preset_minutes,
    output logic [W-1:0] alarm_hours,
    output logic [W-1:0] alarm_minutes,
    output logic         armed,
    output logic         buzzer,
    output logic [2:0]   mode
);
    localparam int RCW = $clog2(RING_TICKS + 1);
    localparam int SCW = $clog2(SNOOZE_TICKS + 1);

    typedef enum logic [2:0] {
        RUN = 3'd0, SET_TH = 3'd1, SET_TM = 3'd2, SET_AH = 3'd3,
        SET_AM = 3'd4, RINGING = 3'd5, SNOOZE = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   edit_h_q, edit_h_d, edit_m_q, edit_m_d;
    logic [W-1:0]   alarm_h_q, alarm_h_d, alarm_m_q, alarm_m_d;
    logic [W-1:0]   preset_h_q, preset_h_d, preset_m_q, preset_m_d;
    logic           armed_q, armed_d, load_q, load_d, match_q, match_d;
    logic [RCW-1:0] ring_cnt_q, ring_cnt_d;
    logic [SCW-1:0] snz_cnt_q, snz_cnt_d;
    logic           match, fire, snooze_limit_hit;

`ifdef SNOOZE_LIMIT_EN
    localparam int TCW = $clog2(MAX_SNOOZE + 1);
    logic [TCW-1:0] snz_taken_q, snz_taken_d;
    assign snooze_limit_hit = (snz_taken_q == TCW'(MAX_SNOOZE));
`else
    // Unlimited snoozes: the cap never engages in this build.
    assign snooze_limit_hit = (MAX_SNOOZE < 0);
`endif

    assign match = (cur_hours == alarm_h_q) && (cur_minutes == alarm_m_q) && (cur_seconds == '0);
    assign fire  = match && !match_q && armed_q && (state_q == RUN);

    always_comb begin
        state_d    = state_q;
        edit_h_d   = edit_h_q;
        edit_m_d   = edit_m_q;
        alarm_h_d  = alarm_h_q;
        alarm_m_d  = alarm_m_q;
        preset_h_d = preset_h_q;
        preset_m_d = preset_m_q;
        armed_d    = armed_q;
        load_d     = 1'b0;
        match_d    = match;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
`ifdef SNOOZE_LIMIT_EN
        snz_taken_d = snz_taken_q;
`endif
        case (state_q)
            RUN: begin
                if (fire) begin
                    state_d    = RINGING;
                    ring_cnt_d = '0;
`ifdef SNOOZE_LIMIT_EN
                    snz_taken_d = '0;
`endif
                end else if (btn_mode) begin
                    state_d  = SET_TH;
                    edit_h_d = cur_hours;
                    edit_m_d = cur_minutes;
                end else if (btn_arm) begin
                    armed_d = !armed_q;
                end
            end
            SET_TH: begin
                if (btn_mode)     state_d  = SET_TM;
                else if (btn_inc) edit_h_d = edit_h_q + W'(1);
            end
            SET_TM: begin
                // Preset is captured separately because the edit regs are reused for the alarm.
                if (btn_mode) begin
                    state_d    = SET_AH;
                    load_d     = 1'b1;
                    preset_h_d = edit_h_q;
                    preset_m_d = edit_m_q;
                    edit_h_d   = alarm_h_q;
                    edit_m_d   = alarm_m_q;
                end else if (btn_inc) begin
                    edit_m_d = edit_m_q + W'(1);
                end
            end
            SET_AH: begin
                if (btn_mode)     state_d  = SET_AM;
                else if (btn_inc) edit_h_d = edit_h_q + W'(1);
            end
            SET_AM: begin
                if (btn_mode) begin
                    state_d   = RUN;
                    alarm_h_d = edit_h_q;
                    alarm_m_d = edit_m_q;
                    armed_d   = 1'b1;
                end else if (btn_inc) begin
                    edit_m_d = edit_m_q + W'(1);
                end
            end
            RINGING: begin
                if (btn_stop || (btn_snooze && snooze_limit_hit)) begin
                    state_d = RUN;
                end else if (btn_snooze) begin
                    state_d   = SNOOZE;
                    snz_cnt_d = SCW'(SNOOZE_TICKS);
`ifdef SNOOZE_LIMIT_EN
                    snz_taken_d = snz_taken_q + TCW'(1);
`endif
                end else if (tick) begin
                    if (ring_cnt_q == RCW'(RING_TICKS - 1)) state_d = RUN;
                    else ring_cnt_d = ring_cnt_q + RCW'(1);
                end
            end
            SNOOZE: begin
                if (btn_stop) begin
                    state_d = RUN;
                end else if (tick) begin
                    if (snz_cnt_q <= SCW'(1)) begin
                        state_d    = RINGING;
                        ring_cnt_d = '0;
                        snz_cnt_d  = '0;
                    end else begin
                        snz_cnt_d = snz_cnt_q - SCW'(1);
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            edit_h_q   <= '0;
            edit_m_q   <= '0;
            alarm_h_q  <= '0;
            alarm_m_q  <= '0;
            preset_h_q <= '0;
            preset_m_q <= '0;
            armed_q    <= 1'b0;
            load_q     <= 1'b0;
            match_q    <= 1'b0;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
`ifdef SNOOZE_LIMIT_EN
            snz_taken_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            edit_h_q   <= edit_h_d;
            edit_m_q   <= edit_m_d;
            alarm_h_q  <= alarm_h_d;
            alarm_m_q  <= alarm_m_d;
            preset_h_q <= preset_h_d;
            preset_m_q <= preset_m_d;
            armed_q    <= armed_d;
            load_q     <= load_d;
            match_q    <= match_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
`ifdef SNOOZE_LIMIT_EN
            snz_taken_q <= snz_taken_d;
`endif
        end
    end

    assign load           = load_q;
    assign preset_hours   = preset_h_q;
    assign preset_minutes = preset_m_q;
    assign alarm_hours    = alarm_h_q;
    assign alarm_minutes  = alarm_m_q;
    assign armed          = armed_q;
    assign buzzer         = (state_q == RINGING);
    assign mode           = state_q;
endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer: vector table for set-up/fire, hand sequences for ring/snooze/reset.
module tb_alarm_sequencer;
    logic       clk = 1'b0, reset = 1'b1, tick = 1'b0;
    logic [1:0] cur_hours = '0, cur_minutes = '0, cur_seconds = '0;
    logic       btn_mode = 0, btn_inc = 0, btn_arm = 0, btn_snooze = 0, btn_stop = 0;
    logic       load, armed, buzzer;
    logic [1:0] preset_hours, preset_minutes, alarm_hours, alarm_minutes;
    logic [2:0] mode;
    int         n_tests = 0, n_fail = 0;

    alarm_sequencer #(.W(2), .RING_TICKS(8), .SNOOZE_TICKS(4), .MAX_SNOOZE(3)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_arm(btn_arm),
        .btn_snooze(btn_snooze), .btn_stop(btn_stop),
        .load(load), .preset_hours(preset_hours), .preset_minutes(preset_minutes),
        .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
        .armed(armed), .buzzer(buzzer), .mode(mode)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // Button bit order: {mode, inc, arm, snooze, stop}
    localparam logic [4:0] BM = 5'b10000, BI = 5'b01000, BA = 5'b00100, BS = 5'b00010, BT = 5'b00001, B0 = 5'b0;
    // Current time {h,m,s}
    localparam logic [5:0] C = 6'b01_10_01, F = 6'b10_01_00, G = 6'b10_01_01;

    typedef struct packed {
        logic [4:0] btn;
        logic       tk;
        logic [5:0] cur;
        logic [2:0] e_mode;
        logic [2:0] e_bal;   // {buzzer, armed, load}
        logic [7:0] e_pa;    // {preset_h, preset_m, alarm_h, alarm_m}
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(logic [4:0] b, logic t, logic [5:0] c, logic [2:0] m,
                                logic [2:0] bal, logic [7:0] pa);
        vec_t v;
        v.btn = b; v.tk = t; v.cur = c; v.e_mode = m; v.e_bal = bal; v.e_pa = pa;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic [4:0] b, input logic t, input logic [5:0] c);
        {btn_mode, btn_inc, btn_arm, btn_snooze, btn_stop} = b;
        tick = t;
        {cur_hours, cur_minutes, cur_seconds} = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(BM,      0, C, 3'd1, 3'b000, 8'b00_00_00_00);
        vecs[1]  = mk(BI,      0, C, 3'd1, 3'b000, 8'b00_00_00_00);
        vecs[2]  = mk(BI,      0, C, 3'd1, 3'b000, 8'b00_00_00_00);
        vecs[3]  = mk(BM,      0, C, 3'd2, 3'b000, 8'b00_00_00_00);
        vecs[4]  = mk(BI,      0, C, 3'd2, 3'b000, 8'b00_00_00_00);
        vecs[5]  = mk(BI,      0, C, 3'd2, 3'b000, 8'b00_00_00_00);
        vecs[6]  = mk(BI,      0, C, 3'd2, 3'b000, 8'b00_00_00_00);
        vecs[7]  = mk(BM,      0, C, 3'd3, 3'b001, 8'b11_01_00_00);
        vecs[8]  = mk(BI,      0, C, 3'd3, 3'b000, 8'b11_01_00_00);
        vecs[9]  = mk(BI,      0, C, 3'd3, 3'b000, 8'b11_01_00_00);
        vecs[10] = mk(BM | BI, 0, C, 3'd4, 3'b000, 8'b11_01_00_00);
        vecs[11] = mk(BI,      0, C, 3'd4, 3'b000, 8'b11_01_00_00);
        vecs[12] = mk(BM,      0, C, 3'd0, 3'b010, 8'b11_01_10_01);
        vecs[13] = mk(BA,      0, C, 3'd0, 3'b000, 8'b11_01_10_01);
        vecs[14] = mk(BA,      0, C, 3'd0, 3'b010, 8'b11_01_10_01);
        vecs[15] = mk(B0,      0, F, 3'd5, 3'b110, 8'b11_01_10_01);
        vecs[16] = mk(BT,      0, F, 3'd0, 3'b010, 8'b11_01_10_01);
        vecs[17] = mk(B0,      0, F, 3'd0, 3'b010, 8'b11_01_10_01);
        vecs[18] = mk(B0,      0, F, 3'd0, 3'b010, 8'b11_01_10_01);
        vecs[19] = mk(B0,      0, F, 3'd0, 3'b010, 8'b11_01_10_01);
        vecs[20] = mk(B0,      0, F, 3'd0, 3'b010, 8'b11_01_10_01);
        vecs[21] = mk(B0,      0, G, 3'd0, 3'b010, 8'b11_01_10_01);
        vecs[22] = mk(B0,      0, F, 3'd5, 3'b110, 8'b11_01_10_01);
        vecs[23] = mk(BA,      0, F, 3'd5, 3'b110, 8'b11_01_10_01);
        vecs[24] = mk(BS | BT, 0, F, 3'd0, 3'b010, 8'b11_01_10_01);

        // Reset state
        cur_hours = 2'd1; cur_minutes = 2'd2; cur_seconds = 2'd1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst mode", mode, 0);
        chk("rst buzzer", buzzer, 0);
        chk("rst armed", armed, 0);
        chk("rst load", load, 0);
        chk("rst alarm", {alarm_hours, alarm_minutes}, 0);
        chk("rst preset", {preset_hours, preset_minutes}, 0);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 25; i++) begin
            cyc(vecs[i].btn, vecs[i].tk, vecs[i].cur);
            chk($sformatf("v%0d mode", i), mode, vecs[i].e_mode);
            chk($sformatf("v%0d buzzer", i), buzzer, vecs[i].e_bal[2]);
            chk($sformatf("v%0d armed", i), armed, vecs[i].e_bal[1]);
            chk($sformatf("v%0d load", i), load, vecs[i].e_bal[0]);
            chk($sformatf("v%0d preset", i), {preset_hours, preset_minutes}, vecs[i].e_pa[7:4]);
            chk($sformatf("v%0d alarm", i), {alarm_hours, alarm_minutes}, vecs[i].e_pa[3:0]);
        end

        // Ring timeout after RING_TICKS ticks
        cyc(B0, 0, G);
        cyc(B0, 0, F);
        chk("to fire mode", mode, 5);
        for (int i = 0; i < 7; i++) cyc(B0, 1, F);
        chk("to tick7 buzzer", buzzer, 1);
        cyc(B0, 1, F);
        chk("to tick8 buzzer", buzzer, 0);
        chk("to tick8 mode", mode, 0);

        // Snooze; inc/mode/snooze ignored while snoozing
        cyc(B0, 0, G);
        cyc(B0, 0, F);
        chk("sn fire mode", mode, 5);
        cyc(BS, 0, F);
        chk("sn mode", mode, 6);
        chk("sn buzzer", buzzer, 0);
        cyc(BM | BI, 0, F);
        chk("sn modeinc ignored", mode, 6);
        cyc(B0, 1, F);
        cyc(B0, 1, F);
        cyc(BS, 0, F);
        chk("sn snooze ignored", mode, 6);
        cyc(B0, 1, F);
        chk("sn tick3 mode", mode, 6);
        cyc(B0, 1, F);
        chk("sn tick4 mode", mode, 5);
        chk("sn tick4 buzzer", buzzer, 1);
        chk("sn alarm kept", {alarm_hours, alarm_minutes}, 4'b10_01);

        // Snoozes two and three, then the fourth press
        for (int k = 0; k < 2; k++) begin
            cyc(BS, 0, F);
            chk($sformatf("lim snooze%0d mode", k + 2), mode, 6);
            for (int i = 0; i < 4; i++) cyc(B0, 1, F);
            chk($sformatf("lim rering%0d mode", k + 2), mode, 5);
        end
        cyc(BS, 0, F);
`ifdef SNOOZE_LIMIT_EN
        chk("lim 4th mode", mode, 0);
        chk("lim 4th buzzer", buzzer, 0);
`else
        chk("lim 4th mode", mode, 6);
        chk("lim 4th buzzer", buzzer, 0);
`endif
        cyc(BT, 0, F);
        chk("lim stop mode", mode, 0);

        // Asynchronous reset in the middle of RINGING
        cyc(B0, 0, G);
        cyc(B0, 0, F);
        chk("rr fire mode", mode, 5);
        #2 reset = 1'b1;
        #1;
        chk("rr mode", mode, 0);
        chk("rr buzzer", buzzer, 0);
        chk("rr armed", armed, 0);
        chk("rr alarm", {alarm_hours, alarm_minutes}, 0);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset while load is high
        cyc(BM, 0, C);
        cyc(BM, 0, C);
        cyc(BM, 0, C);
        chk("rl load", load, 1);
        chk("rl preset", {preset_hours, preset_minutes}, 4'b01_10);
        #2 reset = 1'b1;
        #1;
        chk("rl load after rst", load, 0);
        chk("rl mode after rst", mode, 0);
        #2 reset = 1'b0;
        cyc(B0, 0, C);
        chk("rl load stays low", load, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
